// File: rtl/pwd_stream_pkg.sv
// Shared definitions for the password symbol stream (transmitter and receiver).
// Holds the symbol and buffer geometry, the transmitter state encoding and the frame length rule.
package pwd_stream_pkg;

  localparam int SYM_W   = 6;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

  // A frame must carry at least one symbol and fit in the buffer.
  function automatic logic len_ok(input logic [LEN_W-1:0] l);
    return (l != '0) && (l <= LEN_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/pwd_stream_tx_if.sv
// Symbol stream bundle between the transmitter (master) and its consumer (slave).
// A symbol moves on a rising edge where m_valid && m_ready; m_data/m_last are stable while m_valid waits.
interface pwd_stream_tx_if;
  import pwd_stream_pkg::*;

  logic             m_valid;
  logic             m_ready;
  logic [SYM_W-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/pwd_sym_buf.sv
// MAX_LEN x SYM_W symbol register file: one write port, one combinational read port.
// Every entry is cleared by the asynchronous reset.
module pwd_sym_buf
  import pwd_stream_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [SYM_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [SYM_W-1:0] rd_data_o
);

  logic [SYM_W-1:0] mem_q [MAX_LEN];
  logic             addr_ok;

  // Out-of-range addresses only exist when MAX_LEN is not a power of two.
  assign addr_ok = ({1'b0, wr_addr_i} < (IDX_W + 1)'(MAX_LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && addr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pwd_stream_tx.sv
// Password symbol transmitter: buffers host-written symbols and, on start, streams
// buf[0..len-1] with a last flag, then pulses done. Bad lengths are refused with err.
module pwd_stream_tx
  import pwd_stream_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  pwd_stream_tx_if.master  m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output tx_state_t        dbg_state
);

  tx_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [SYM_W-1:0] rd_data;
  logic             is_last;
  logic             buf_wr_en;

  // The frame is immutable while it is being sent.
  assign buf_wr_en = wr_en && (state_q != SEND);

  pwd_sym_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  assign is_last = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok(len)) begin
            state_d = SEND;
            len_d   = len;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (m.m_ready) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    // DONE lasts exactly one cycle, so entering it is the done pulse.
    done_d = (state_d == DONE);
  end

  always_comb begin
    m.m_valid = (state_q == SEND);
    m.m_data  = (state_q == SEND) ? rd_data : '0;
    m.m_last  = (state_q == SEND) && is_last;
    busy      = (state_q != IDLE);
    done      = done_q;
    err       = err_q;
    dbg_state = state_q;
  end

endmodule
